booth_multiplier: RTL and testbench

BOOTH_MULTIPLIER -- requirements
Module: booth_multiplier

---
 rtl/booth_pkg.sv | 7 +
 rtl/booth_step.sv | 25 ++
 rtl/booth_multiplier.sv | 70 +++++++
 tb/tb_booth_multiplier.sv | 130 +++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// booth_pkg: shared FSM states, default operand width and Booth pair encodings
package booth_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam int DEFAULT_WIDTH = 8;
  localparam logic [1:0] PAIR_ADD = 2'b01;
  localparam logic [1:0] PAIR_SUB = 2'b10;
endpackage

// File: rtl/booth_step.sv
// booth_step: one radix-2 Booth step (add/sub M, then arithmetic shift of {a, q, q_m1}); ports a/q/q_m1/m in, a_n/q_n/q_m1_n out
module booth_step
  import booth_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH+1:0] a,
  input  logic [WIDTH:0]   q,
  input  logic             q_m1,
  input  logic [WIDTH:0]   m,
  output logic [WIDTH+1:0] a_n,
  output logic [WIDTH:0]   q_n,
  output logic             q_m1_n
);
  logic [WIDTH+1:0] m_x;
  logic [WIDTH+1:0] sum;
  always_comb begin
    m_x = {m[WIDTH], m};
    sum = ({q[0], q_m1} == PAIR_ADD) ? a + m_x :
          ({q[0], q_m1} == PAIR_SUB) ? a - m_x : a;
    a_n = {sum[WIDTH+1], sum[WIDTH+1:1]};
    q_n = {sum[0], q[WIDTH:1]};
    q_m1_n = q[0];
  end
endmodule

// File: rtl/booth_multiplier.sv
// booth_multiplier: sequential radix-2 Booth multiplier; start/tc/multiplicand/multiplier in, busy/done/product out
module booth_multiplier
  import booth_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               tc,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH + 2);
  state_t state;
  logic [WIDTH+1:0] a, a_n;
  logic [WIDTH:0] q, q_n, m;
  logic q_m1, q_m1_n, tc_r;
  logic [CW-1:0] cnt;
  booth_step #(.WIDTH(WIDTH)) u_step (
    .a(a), .q(q), .q_m1(q_m1), .m(m),
    .a_n(a_n), .q_n(q_n), .q_m1_n(q_m1_n)
  );
  assign busy = state == CALC;
  // Signed runs stop one shift short of the unsigned run, so the product sits one bit higher in {a, q}
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      a <= '0;
      q <= '0;
      q_m1 <= 1'b0;
      m <= '0;
      tc_r <= 1'b0;
      cnt <= '0;
      done <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        CALC: begin
          a <= a_n;
          q <= q_n;
          q_m1 <= q_m1_n;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state <= DONE;
            done <= 1'b1;
            product <= tc_r ? {a_n[WIDTH-1:0], q_n[WIDTH:1]} : {a_n[WIDTH-2:0], q_n};
          end
        end
        default: begin
          if (start) begin
            state <= CALC;
            a <= '0;
            q <= {tc & multiplier[WIDTH-1], multiplier};
            q_m1 <= 1'b0;
            m <= {tc & multiplicand[WIDTH-1], multiplicand};
            tc_r <= tc;
            cnt <= tc ? CW'(WIDTH) : CW'(WIDTH + 1);
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_booth_multiplier.sv
// tb_booth_multiplier: directed-vector bench for booth_multiplier at WIDTH=4 and WIDTH=8
module tb_booth_multiplier;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, start, tc, busy, done;
  logic [3:0] mc, mp;
  logic [7:0] product;
  logic start8, tc8, busy8, done8;
  logic [7:0] mc8, mp8;
  logic [15:0] product8;
  int vectors = 0;
  int errors = 0;
  booth_multiplier #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .tc(tc),
    .multiplicand(mc), .multiplier(mp),
    .busy(busy), .done(done), .product(product)
  );
  booth_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .tc(tc8),
    .multiplicand(mc8), .multiplier(mp8),
    .busy(busy8), .done(done8), .product(product8)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic mul4(input string tag, input logic t, input logic [3:0] m, input logic [3:0] q, input logic [7:0] exp);
    int n;
    n = t ? 4 : 5;
    tc = t; mc = m; mp = q; start = 1'b1;
    tick;
    start = 1'b0; tc = ~t; mc = ~m; mp = ~q;
    check({tag, " busy"}, 32'(busy), 32'd1);
    for (int i = 1; i < n; i++) begin
      tick;
      check({tag, " early done"}, 32'(done), 32'd0);
      check({tag, " busy hold"}, 32'(busy), 32'd1);
    end
    tick;
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " busy off"}, 32'(busy), 32'd0);
    check({tag, " product"}, 32'(product), 32'(exp));
    tick;
    check({tag, " done fall"}, 32'(done), 32'd0);
    check({tag, " product hold"}, 32'(product), 32'(exp));
  endtask
  task automatic mul8(input string tag, input logic t, input logic [7:0] m, input logic [7:0] q, input logic [15:0] exp);
    int n;
    n = t ? 8 : 9;
    tc8 = t; mc8 = m; mp8 = q; start8 = 1'b1;
    tick;
    start8 = 1'b0;
    for (int i = 1; i < n; i++) tick;
    check({tag, " early done"}, 32'(done8), 32'd0);
    tick;
    check({tag, " done"}, 32'(done8), 32'd1);
    check({tag, " product"}, 32'(product8), 32'(exp));
  endtask
  initial begin
    reset = 1'b1; start = 1'b1; tc = 1'b1; mc = 4'd3; mp = 4'd2;
    start8 = 1'b0; tc8 = 1'b0; mc8 = '0; mp8 = '0;
    tick;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset product", 32'(product), 32'd0);
    tick;
    check("reset priority busy", 32'(busy), 32'd0);
    reset = 1'b0; start = 1'b0;
    tick;
    mul4("s 3*2", 1'b1, 4'd3, 4'd2, 8'h06);
    mul4("s -8*-8", 1'b1, 4'b1000, 4'b1000, 8'h40);
    mul4("s 4*-3", 1'b1, 4'b0100, 4'b1101, 8'hF4);
    mul4("u 15*15", 1'b0, 4'd15, 4'd15, 8'hE1);
    mul4("u 0*0", 1'b0, 4'd0, 4'd0, 8'h00);
    mul4("s -1*-1", 1'b1, 4'hF, 4'hF, 8'h01);
    mul4("s 7*-8", 1'b1, 4'd7, 4'b1000, 8'hC8);
    mul4("u 8*8", 1'b0, 4'd8, 4'd8, 8'h40);
    // start mid-CALC ignored, then back-to-back accept in DONE
    tc = 1'b1; mc = 4'd3; mp = 4'd5; start = 1'b1;
    tick;
    tc = 1'b0; mc = 4'd2; mp = 4'd7;
    tick;
    start = 1'b0; mc = 4'd9; mp = 4'd9;
    tick;
    tick;
    tick;
    check("b2b first done", 32'(done), 32'd1);
    check("b2b first product", 32'(product), 32'h0F);
    tc = 1'b1; mc = 4'b1110; mp = 4'd3; start = 1'b1;
    tick;
    start = 1'b0;
    check("b2b accept busy", 32'(busy), 32'd1);
    check("b2b accept done", 32'(done), 32'd0);
    check("b2b product held", 32'(product), 32'h0F);
    for (int i = 1; i < 4; i++) tick;
    check("b2b early done", 32'(done), 32'd0);
    tick;
    check("b2b second done", 32'(done), 32'd1);
    check("b2b second product", 32'(product), 32'hFA);
    tick;
    // reset two cycles into CALC aborts with no done pulse
    tc = 1'b1; mc = 4'd5; mp = 4'd3; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort product", 32'(product), 32'h00);
    for (int i = 0; i < 6; i++) begin
      tick;
      check("abort no done", 32'(done), 32'd0);
    end
    mul4("post reset 5*3", 1'b1, 4'd5, 4'd3, 8'h0F);
    mul8("w8 u 200*150", 1'b0, 8'd200, 8'd150, 16'h7530);
    mul8("w8 s -100*50", 1'b1, 8'(-100), 8'd50, 16'hEC78);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
